// File: rtl/wb_regfile_pkg.sv
`default_nettype none
// ============================================================================
// Module   : wb_regfile_pkg
// Purpose  : Shared pipeline constants for the write-back / register-file
//            stage: data width, register address width, register count and
//            the hard-wired zero register address.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package wb_regfile_pkg;

  localparam int WB_DATA_W   = 32;
  localparam int WB_ADDR_W   = 5;
  localparam int WB_NREG     = 32;   // 2**WB_ADDR_W
  localparam int WB_REG_ZERO = 0;    // architectural zero register

  // Write-back bypass bundle as seen by a read port.
  typedef struct packed {
    logic                 valid;
    logic [WB_ADDR_W-1:0] addr;
    logic [WB_DATA_W-1:0] data;
  } wb_bypass_t;

endpackage : wb_regfile_pkg
`default_nettype wire

// File: rtl/wb_regfile_rdport.sv
`default_nettype none
// ============================================================================
// Module   : wb_regfile_rdport
// Purpose  : One combinational register-file read port with write-through
//            bypass of the write-back value in flight this cycle.
// Ports    : i_rd_addr   - register address to read
//            i_regs      - view of the stored register array
//            i_byp_valid - a write-back commits this cycle
//            i_byp_addr  - destination of that write-back
//            i_byp_data  - value being written back
//            o_rd_data   - read data
// Revision : 1.0 - initial release
// ============================================================================
module wb_regfile_rdport
  import wb_regfile_pkg::*;
#(
  parameter int DATA_W = WB_DATA_W,
  parameter int ADDR_W = WB_ADDR_W,
  parameter int NREG   = WB_NREG
) (
  input  logic [ADDR_W-1:0]           i_rd_addr,
  input  logic [NREG-1:0][DATA_W-1:0] i_regs,
  input  logic                        i_byp_valid,
  input  logic [ADDR_W-1:0]           i_byp_addr,
  input  logic [DATA_W-1:0]           i_byp_data,
  output logic [DATA_W-1:0]           o_rd_data
);

  always_comb begin
    o_rd_data = i_regs[i_rd_addr];
    // Zero register wins over everything; bypass valid already excludes
    // address zero, but keeping it explicit makes the port self-contained.
    if (i_rd_addr == ADDR_W'(WB_REG_ZERO)) begin
      o_rd_data = '0;
    end else if (i_byp_valid && (i_rd_addr == i_byp_addr)) begin
      o_rd_data = i_byp_data;
    end
  end

endmodule : wb_regfile_rdport
`default_nettype wire

// File: rtl/wb_regfile.sv
`default_nettype none
// ============================================================================
// Module   : wb_regfile
// Purpose  : Write-back stage and architectural register file. Selects the
//            write-back source, commits it to a flop-based register array,
//            exposes two bypassed combinational read ports, drives the EX
//            forwarding bus and counts retired register writes.
// Ports    : clk, nrst                 - clock, synchronous active-low reset
//            i_WB_ctrl_*               - write-back control (source, enable)
//            i_WB_data_*               - destination and candidate data
//            i_ID_RegAddrA/B           - decode read addresses
//            o_ID_RegDataA/B           - decode read data
//            o_FWD_valid/addr/data     - forwarding of the committing result
//            o_WB_retire_cnt           - committed register write count
// Revision : 1.0 - initial release
// ============================================================================
module wb_regfile
  import wb_regfile_pkg::*;
#(
  parameter int DATA_W = WB_DATA_W,
  parameter int ADDR_W = WB_ADDR_W,
  parameter int NREG   = WB_NREG
) (
  input  logic              clk,
  input  logic              nrst,
  input  logic              i_WB_ctrl_Mem2Reg,
  input  logic              i_WB_ctrl_RegWrite,
  input  logic [ADDR_W-1:0] i_WB_data_RegAddrW,
  input  logic [DATA_W-1:0] i_WB_data_MemData,
  input  logic [DATA_W-1:0] i_WB_data_ALUData,
  input  logic [ADDR_W-1:0] i_ID_RegAddrA,
  input  logic [ADDR_W-1:0] i_ID_RegAddrB,
  output logic [DATA_W-1:0] o_ID_RegDataA,
  output logic [DATA_W-1:0] o_ID_RegDataB,
  output logic              o_FWD_valid,
  output logic [ADDR_W-1:0] o_FWD_addr,
  output logic [DATA_W-1:0] o_FWD_data,
  output logic [31:0]       o_WB_retire_cnt
);

  logic [DATA_W-1:0]           wb_data;
  logic                        commit;
  logic [NREG-1:0][DATA_W-1:0] regs_d;
  logic [NREG-1:0][DATA_W-1:0] regs_q;
  logic [31:0]                 retire_cnt_d;
  logic [31:0]                 retire_cnt_q;

  assign wb_data = i_WB_ctrl_Mem2Reg ? i_WB_data_MemData : i_WB_data_ALUData;

  // nrst is part of the commit term so that both the forwarding bus and the
  // read-port bypass go quiet during reset, not just the storage update.
  assign commit = i_WB_ctrl_RegWrite
                & (i_WB_data_RegAddrW != ADDR_W'(WB_REG_ZERO))
                & nrst;

  always_comb begin
    regs_d       = regs_q;
    retire_cnt_d = retire_cnt_q;
    if (commit) begin
      regs_d[i_WB_data_RegAddrW] = wb_data;
      retire_cnt_d               = retire_cnt_q + 32'd1;  // wraps naturally
    end
    regs_d[WB_REG_ZERO] = '0;
  end

  always_ff @(posedge clk) begin
    if (!nrst) begin
      regs_q       <= '0;
      retire_cnt_q <= '0;
    end else begin
      regs_q       <= regs_d;
      retire_cnt_q <= retire_cnt_d;
    end
  end

  wb_regfile_rdport #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .NREG   (NREG)
  ) u_rdport_a (
    .i_rd_addr   (i_ID_RegAddrA),
    .i_regs      (regs_q),
    .i_byp_valid (commit),
    .i_byp_addr  (i_WB_data_RegAddrW),
    .i_byp_data  (wb_data),
    .o_rd_data   (o_ID_RegDataA)
  );

  wb_regfile_rdport #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .NREG   (NREG)
  ) u_rdport_b (
    .i_rd_addr   (i_ID_RegAddrB),
    .i_regs      (regs_q),
    .i_byp_valid (commit),
    .i_byp_addr  (i_WB_data_RegAddrW),
    .i_byp_data  (wb_data),
    .o_rd_data   (o_ID_RegDataB)
  );

  assign o_FWD_valid     = commit;
  assign o_FWD_addr      = i_WB_data_RegAddrW;
  assign o_FWD_data      = wb_data;
  assign o_WB_retire_cnt = retire_cnt_q;

endmodule : wb_regfile
`default_nettype wire

// File: tb/tb_wb_regfile.sv
`default_nettype none
// ============================================================================
// Module   : tb_wb_regfile
// Purpose  : Self-checking bench for wb_regfile. A driver applies directed
//            vectors and queues the hand-computed expected outputs; a monitor
//            pops and compares them on the falling edge.
// Revision : 1.0 - initial release
// ============================================================================
module tb_wb_regfile;

  localparam int S_RDA  = 0;
  localparam int S_RDB  = 1;
  localparam int S_FV   = 2;
  localparam int S_FA   = 3;
  localparam int S_FD   = 4;
  localparam int S_CNT  = 5;

  typedef struct {
    string       name;
    int          sig;
    logic [31:0] exp;
  } exp_t;

  logic        clk;
  logic        nrst;
  logic        mem2reg;
  logic        regwrite;
  logic [4:0]  addr_w;
  logic [31:0] mem_data;
  logic [31:0] alu_data;
  logic [4:0]  addr_a;
  logic [4:0]  addr_b;
  logic [31:0] data_a;
  logic [31:0] data_b;
  logic        fwd_valid;
  logic [4:0]  fwd_addr;
  logic [31:0] fwd_data;
  logic [31:0] retire_cnt;

  exp_t sb[$];
  int   n_tests;
  int   n_fail;

  wb_regfile u_dut (
    .clk                (clk),
    .nrst               (nrst),
    .i_WB_ctrl_Mem2Reg  (mem2reg),
    .i_WB_ctrl_RegWrite (regwrite),
    .i_WB_data_RegAddrW (addr_w),
    .i_WB_data_MemData  (mem_data),
    .i_WB_data_ALUData  (alu_data),
    .i_ID_RegAddrA      (addr_a),
    .i_ID_RegAddrB      (addr_b),
    .o_ID_RegDataA      (data_a),
    .o_ID_RegDataB      (data_b),
    .o_FWD_valid        (fwd_valid),
    .o_FWD_addr         (fwd_addr),
    .o_FWD_data         (fwd_data),
    .o_WB_retire_cnt    (retire_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] pick(input int s);
    case (s)
      S_RDA:   pick = data_a;
      S_RDB:   pick = data_b;
      S_FV:    pick = {31'd0, fwd_valid};
      S_FA:    pick = {27'd0, fwd_addr};
      S_FD:    pick = fwd_data;
      default: pick = retire_cnt;
    endcase
  endfunction

  task automatic expect_val(input string n, input int s, input logic [31:0] v);
    exp_t e;
    e.name = n;
    e.sig  = s;
    e.exp  = v;
    sb.push_back(e);
  endtask

  // Inputs change 1 time unit after the rising edge; the monitor compares at
  // the following falling edge, so every queued expectation refers to the
  // vector applied in the same cycle.
  task automatic step(input logic rn, input logic we, input logic m2r,
                      input logic [4:0] aw, input logic [31:0] md,
                      input logic [31:0] ad, input logic [4:0] ra,
                      input logic [4:0] rb);
    @(posedge clk);
    #1;
    nrst     = rn;
    regwrite = we;
    mem2reg  = m2r;
    addr_w   = aw;
    mem_data = md;
    alu_data = ad;
    addr_a   = ra;
    addr_b   = rb;
  endtask

  // Monitor
  initial begin
    exp_t        e;
    logic [31:0] act;
    forever begin
      @(negedge clk);
      while (sb.size() > 0) begin
        e   = sb.pop_front();
        act = pick(e.sig);
        n_tests++;
        if (act !== e.exp) begin
          n_fail++;
          $display("FAIL %s: got 0x%08h expected 0x%08h", e.name, act, e.exp);
        end
      end
    end
  end

  // Watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "timeout");
  end

  // Driver
  initial begin
    n_tests  = 0;
    n_fail   = 0;
    nrst     = 1'b0;
    regwrite = 1'b1;
    mem2reg  = 1'b0;
    addr_w   = 5'd5;
    mem_data = 32'd0;
    alu_data = 32'h1234;
    addr_a   = 5'd5;
    addr_b   = 5'd5;

    // Reset held for two edges with a write-back pending
    step(1'b0, 1'b1, 1'b0, 5'd5, 32'd0, 32'h1234, 5'd5, 5'd5);
    step(1'b0, 1'b1, 1'b0, 5'd5, 32'd0, 32'h1234, 5'd5, 5'd5);
    expect_val("rst_rdA",    S_RDA, 32'h0);
    expect_val("rst_rdB",    S_RDB, 32'h0);
    expect_val("rst_fwd_v",  S_FV,  32'h0);
    expect_val("rst_fwd_a",  S_FA,  32'h5);
    expect_val("rst_cnt",    S_CNT, 32'h0);

    for (int i = 0; i < 16; i++) begin
      step(1'b1, 1'b0, 1'b0, 5'd0, 32'd0, 32'd0, 5'(i), 5'(i + 16));
      expect_val($sformatf("rst_reg%0d", i),      S_RDA, 32'h0);
      expect_val($sformatf("rst_reg%0d", i + 16), S_RDB, 32'h0);
    end

    // Source select: MemData
    step(1'b1, 1'b1, 1'b1, 5'd3, 32'hDEADBEEF, 32'h11, 5'd0, 5'd0);
    expect_val("mem_fwd_v", S_FV, 32'h1);
    expect_val("mem_fwd_a", S_FA, 32'h3);
    expect_val("mem_fwd_d", S_FD, 32'hDEADBEEF);
    step(1'b1, 1'b0, 1'b0, 5'd0, 32'd0, 32'd0, 5'd3, 5'd0);
    expect_val("mem_rd3", S_RDA, 32'hDEADBEEF);
    expect_val("mem_cnt", S_CNT, 32'd1);

    // Source select: ALUData
    step(1'b1, 1'b1, 1'b0, 5'd4, 32'hDEADBEEF, 32'h11, 5'd0, 5'd0);
    expect_val("alu_fwd_d", S_FD, 32'h11);
    step(1'b1, 1'b0, 1'b0, 5'd0, 32'd0, 32'd0, 5'd4, 5'd3);
    expect_val("alu_rd4", S_RDA, 32'h11);
    expect_val("alu_rd3", S_RDB, 32'hDEADBEEF);
    expect_val("alu_cnt", S_CNT, 32'd2);

    // Write-through bypass on both ports
    step(1'b1, 1'b1, 1'b0, 5'd7, 32'd0, 32'hAAAA, 5'd0, 5'd0);
    step(1'b1, 1'b1, 1'b0, 5'd7, 32'd0, 32'h5555, 5'd7, 5'd7);
    expect_val("byp_rdA", S_RDA, 32'h5555);
    expect_val("byp_rdB", S_RDB, 32'h5555);
    expect_val("byp_cnt", S_CNT, 32'd3);
    step(1'b1, 1'b0, 1'b0, 5'd0, 32'd0, 32'd0, 5'd7, 5'd7);
    expect_val("byp_post_rdA", S_RDA, 32'h5555);
    expect_val("byp_post_rdB", S_RDB, 32'h5555);
    expect_val("byp_post_cnt", S_CNT, 32'd4);

    // Write to register 0 is ignored
    step(1'b1, 1'b1, 1'b0, 5'd0, 32'd0, 32'hFFFF, 5'd0, 5'd7);
    expect_val("r0_rdA",   S_RDA, 32'h0);
    expect_val("r0_fwd_v", S_FV,  32'h0);
    expect_val("r0_fwd_d", S_FD,  32'hFFFF);
    step(1'b1, 1'b0, 1'b0, 5'd0, 32'd0, 32'd0, 5'd0, 5'd0);
    expect_val("r0_post_rdA", S_RDA, 32'h0);
    expect_val("r0_post_cnt", S_CNT, 32'd4);

    // Back-to-back commits to register 9
    step(1'b1, 1'b1, 1'b0, 5'd9, 32'd0, 32'h1, 5'd9, 5'd0);
    step(1'b1, 1'b1, 1'b0, 5'd9, 32'd0, 32'h2, 5'd9, 5'd0);
    expect_val("b2b_byp2", S_RDA, 32'h2);
    step(1'b1, 1'b1, 1'b0, 5'd9, 32'd0, 32'h3, 5'd0, 5'd0);
    step(1'b1, 1'b0, 1'b0, 5'd0, 32'd0, 32'd0, 5'd9, 5'd9);
    expect_val("b2b_rdA", S_RDA, 32'h3);
    expect_val("b2b_cnt", S_CNT, 32'd7);

    // Reset asserted mid-operation discards the concurrent write-back
    step(1'b1, 1'b1, 1'b0, 5'd10, 32'd0, 32'h77, 5'd0, 5'd0);
    step(1'b0, 1'b1, 1'b0, 5'd10, 32'd0, 32'h99, 5'd10, 5'd10);
    expect_val("mrst_fwd_v", S_FV,  32'h0);
    expect_val("mrst_rdA",   S_RDA, 32'h77);
    expect_val("mrst_cnt",   S_CNT, 32'd8);
    step(1'b1, 1'b0, 1'b0, 5'd0, 32'd0, 32'd0, 5'd10, 5'd9);
    expect_val("mrst_post_rdA", S_RDA, 32'h0);
    expect_val("mrst_post_rdB", S_RDB, 32'h0);
    expect_val("mrst_post_cnt", S_CNT, 32'd0);

    // Counter wrap
    step(1'b1, 1'b0, 1'b0, 5'd0, 32'd0, 32'd0, 5'd0, 5'd0);
    force u_dut.retire_cnt_q = 32'hFFFF_FFFF;
    #1;
    release u_dut.retire_cnt_q;
    step(1'b1, 1'b1, 1'b0, 5'd2, 32'd0, 32'h5, 5'd0, 5'd0);
    expect_val("wrap_pre_cnt", S_CNT, 32'hFFFF_FFFF);
    expect_val("wrap_fwd_v",   S_FV,  32'h1);
    step(1'b1, 1'b0, 1'b0, 5'd0, 32'd0, 32'd0, 5'd2, 5'd2);
    expect_val("wrap_cnt", S_CNT, 32'h0);
    expect_val("wrap_rdA", S_RDA, 32'h5);

    // Drain
    repeat (2) @(negedge clk);
    #1;
    n_tests++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d pending expected 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_wb_regfile
`default_nettype wire
